// File: rtl/fc1_bias_act_if.sv
// ---------------------------------------------------------------------------
// fc1_bias_act_if
//   Bundles every bus signal of the FC1 bias/activation stage:
//   - clr                 : synchronous frame restart
//   - acc_valid/ready/data: raw MAC sums from the accumulator (NUM lanes)
//   - bias_aa/cena/qa     : FC1 bias ROM port (registered read, cena low)
//   - out_valid/ready/... : activation beats to the FC2 input buffer
//
//   modport master : the fc1_bias_act stage itself
//   modport slave  : the surroundings (accumulator, ROM, FC2 buffer)
// ---------------------------------------------------------------------------
interface fc1_bias_act_if #(
    parameter int NUM    = 16,
    parameter int ADDR_W = 3,
    parameter int W_ACC  = 34,
    parameter int W_BIAS = 34,
    parameter int W_OUT  = 8
);
    logic                    clr;

    logic                    acc_valid;
    logic                    acc_ready;
    logic [NUM*W_ACC-1:0]    acc_data;

    logic [ADDR_W-1:0]       bias_aa;
    logic                    bias_cena;
    logic [NUM*W_BIAS-1:0]   bias_qa;

    logic                    out_valid;
    logic                    out_ready;
    logic [NUM*W_OUT-1:0]    out_data;
    logic [ADDR_W-1:0]       out_batch;
    logic                    out_last;

    modport master (
        input  clr,
        input  acc_valid, acc_data,
        output acc_ready,
        output bias_aa, bias_cena,
        input  bias_qa,
        output out_valid, out_data, out_batch, out_last,
        input  out_ready
    );

    modport slave (
        output clr,
        output acc_valid, acc_data,
        input  acc_ready,
        input  bias_aa, bias_cena,
        output bias_qa,
        input  out_valid, out_data, out_batch, out_last,
        output out_ready
    );
endinterface

// File: rtl/fc1_bias_act.sv
// ---------------------------------------------------------------------------
// fc1_bias_act
//   Post-accumulator stage of the FC1 layer. Each accepted beat carries NUM
//   raw signed MAC sums for one output batch. The stage reads that batch's
//   biases from the FC1 bias ROM, adds them, applies ReLU, rounds half up,
//   shifts right by SHIFT and saturates to W_OUT-bit unsigned activations.
//
//   Ports:
//     clk   : clock
//     rstn  : asynchronous active-low reset
//     bus   : fc1_bias_act_if.master
//             clr, acc_valid/acc_ready/acc_data (input beat),
//             bias_aa/bias_cena/bias_qa (ROM port),
//             out_valid/out_ready/out_data/out_batch/out_last (output beat)
//
//   Flow per beat: IDLE (accept + ROM read) -> BIAS (compute) -> OUT
//   (hold until out_ready) -> IDLE. One beat every 3 cycles at best.
// ---------------------------------------------------------------------------
module fc1_bias_act #(
    parameter int NUM    = 16,
    parameter int BATCH  = 4,
    parameter int ADDR_W = 3,
    parameter int W_ACC  = 34,
    parameter int W_BIAS = 34,
    parameter int W_OUT  = 8,
    parameter int SHIFT  = 16
) (
    input  logic            clk,
    input  logic            rstn,
    fc1_bias_act_if.master  bus
);

    // One extra bit over the wider operand makes the bias add overflow-free;
    // one more bit leaves room for the rounding constant.
    localparam int W_SUM = ((W_ACC > W_BIAS) ? W_ACC : W_BIAS) + 1;
    localparam int W_RND = W_SUM + 1;

    localparam logic [W_RND-1:0]  HALF       = W_RND'(1) << (SHIFT - 1);
    localparam logic [ADDR_W-1:0] LAST_BATCH = ADDR_W'(BATCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIAS = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]      batch_cnt_reg, batch_cnt_next;
    logic [NUM*W_ACC-1:0]   acc_reg;
    logic [NUM*W_OUT-1:0]   out_data_reg;
    logic                   out_valid_reg, out_valid_next;
    logic                   out_last_reg, out_last_next;
    logic [ADDR_W-1:0]      out_batch_reg, out_batch_next;

    logic                   acc_ready_int;
    logic                   accept;
    logic                   load_acc;
    logic                   load_out;
    logic                   bias_cena_int;
    logic [NUM*W_OUT-1:0]   lane_result;

    // Ready is gated by rstn so the stage never advertises space while the
    // reset is held, even though the state register already reads IDLE.
    assign acc_ready_int = rstn && (state_reg == IDLE);

    // clr beats a same-cycle handshake: the beat is dropped and no ROM read
    // is issued for it.
    assign accept = acc_ready_int && bus.acc_valid && !bus.clr;

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        batch_cnt_next = batch_cnt_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_batch_next = out_batch_reg;
        load_acc       = 1'b0;
        load_out       = 1'b0;
        bias_cena_int  = 1'b1;

        if (bus.clr) begin
            state_next     = IDLE;
            batch_cnt_next = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // ROM read issued in the accept cycle so bias_qa is
                        // ready exactly when the registered sums are.
                        load_acc      = 1'b1;
                        bias_cena_int = 1'b0;
                        state_next    = BIAS;
                    end
                end
                BIAS: begin
                    load_out       = 1'b1;
                    out_valid_next = 1'b1;
                    out_batch_next = batch_cnt_reg;
                    out_last_next  = (batch_cnt_reg == LAST_BATCH);
                    state_next     = OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        batch_cnt_next = (batch_cnt_reg == LAST_BATCH)
                                         ? '0 : batch_cnt_reg + ADDR_W'(1);
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            batch_cnt_reg <= '0;
            acc_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_batch_reg <= '0;
        end else begin
            state_reg     <= state_next;
            batch_cnt_reg <= batch_cnt_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_batch_reg <= out_batch_next;
            if (load_acc) begin
                acc_reg <= bus.acc_data;
            end
            if (load_out) begin
                out_data_reg <= lane_result;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-lane bias add, ReLU, round half up, shift, saturate
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
            logic signed [W_ACC-1:0]  acc_lane;
            logic signed [W_BIAS-1:0] bias_lane;
            logic signed [W_SUM-1:0]  sum;
            logic [W_RND-1:0]         rnd;
            logic [W_RND-1:0]         shifted;
            logic                     sat;

            assign acc_lane  = acc_reg[gi*W_ACC +: W_ACC];
            assign bias_lane = bus.bias_qa[gi*W_BIAS +: W_BIAS];

            // Size casts of signed operands sign-extend to W_SUM.
            assign sum = W_SUM'(acc_lane) + W_SUM'(bias_lane);

            // Only meaningful when sum is non-negative; the sign bit then
            // contributes nothing, so the magnitude bits are zero-extended.
            assign rnd     = {2'b00, sum[W_SUM-2:0]} + HALF;
            assign shifted = rnd >> SHIFT;
            assign sat     = |shifted[W_RND-1:W_OUT];

            assign lane_result[gi*W_OUT +: W_OUT] =
                sum[W_SUM-1] ? '0 :
                sat          ? '1 :
                               shifted[W_OUT-1:0];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.acc_ready = acc_ready_int;
    assign bus.bias_aa   = batch_cnt_reg;
    assign bus.bias_cena = bias_cena_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_batch = out_batch_reg;
    assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_fc1_bias_act.sv
// ---------------------------------------------------------------------------
// tb_fc1_bias_act
//   Self-checking bench for fc1_bias_act: behavioural bias ROM, a monitor
//   logging output transfers and ROM reads, a table of hand-computed beats,
//   hand-written corner sequences and a randomized run against an
//   arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fc1_bias_act;

    localparam int NUM    = 16;
    localparam int BATCH  = 4;
    localparam int ADDR_W = 3;
    localparam int W_ACC  = 34;
    localparam int W_BIAS = 34;
    localparam int W_OUT  = 8;
    localparam int SHIFT  = 16;
    localparam int AW     = NUM*W_ACC;
    localparam int OW     = NUM*W_OUT;

    localparam longint MAX34 = (longint'(1) << 33) - 1;
    localparam longint MIN34 = -(longint'(1) << 33);

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    fc1_bias_act_if #(.NUM(NUM), .ADDR_W(ADDR_W), .W_ACC(W_ACC),
                      .W_BIAS(W_BIAS), .W_OUT(W_OUT)) bus ();

    fc1_bias_act #(.NUM(NUM), .BATCH(BATCH), .ADDR_W(ADDR_W), .W_ACC(W_ACC),
                   .W_BIAS(W_BIAS), .W_OUT(W_OUT), .SHIFT(SHIFT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- bias ROM (registered read, enable active low) --------
    longint              rom [BATCH][NUM];
    logic [NUM*W_BIAS-1:0] rom_word [8];

    always @(posedge clk) begin
        if (!bus.bias_cena) bus.bias_qa <= rom_word[bus.bias_aa];
    end

    // ---------------- monitor ----------------------------------------------
    typedef struct {
        logic [OW-1:0] data;
        int            batch;
        logic          last;
    } xfer_t;

    xfer_t out_log [$];
    int    rd_log  [$];

    always @(negedge clk) begin
        if (rstn) begin
            if (!bus.bias_cena) rd_log.push_back(int'(bus.bias_aa));
            if (bus.out_valid && bus.out_ready && !bus.clr)
                out_log.push_back('{bus.out_data, int'(bus.out_batch), bus.out_last});
        end
    end

    // ---------------- checking helpers -------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int model_batch = 0;

    task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", nm, got);
        end
    endtask

    // Reference: plain integer arithmetic on each lane.
    function automatic logic [OW-1:0] model(input logic [AW-1:0] acc, input int b);
        logic [OW-1:0]           res;
        logic signed [W_ACC-1:0] a_s;
        longint                  s, r;
        res = '0;
        for (int l = 0; l < NUM; l++) begin
            a_s = acc[l*W_ACC +: W_ACC];
            s   = longint'(a_s) + rom[b][l];
            if (s < 0) r = 0;
            else begin
                r = (s + (longint'(1) << (SHIFT-1))) / (longint'(1) << SHIFT);
                if (r > (longint'(1) << W_OUT) - 1) r = (longint'(1) << W_OUT) - 1;
            end
            res[l*W_OUT +: W_OUT] = r[W_OUT-1:0];
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] set_lane(input logic [AW-1:0] v, input int l, input longint x);
        logic [AW-1:0] t;
        t = v;
        t[l*W_ACC +: W_ACC] = x[W_ACC-1:0];
        return t;
    endfunction

    function automatic longint rnd_lane(input int b, input int l);
        logic signed [W_ACC-1:0] v;
        case ($urandom_range(3, 0))
            0: begin
                v = W_ACC'({$urandom(), $urandom()});
                return longint'(v);
            end
            1, 2: return -rom[b][l] + longint'($urandom_range(0, 300*65536)) - 10*65536;
            default: return longint'($urandom_range(0, 134217728)) - 67108864;
        endcase
    endfunction

    function automatic logic [AW-1:0] rand_acc(input int b);
        logic [AW-1:0] v;
        v = '0;
        for (int l = 0; l < NUM; l++) v = set_lane(v, l, rnd_lane(b, l));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] acc);
        bit ok;
        ok = 1'b0;
        bus.acc_valid = 1'b1;
        bus.acc_data  = acc;
        for (int n = 0; n < 20; n++) begin
            if (bus.acc_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        bus.acc_valid = 1'b0;
        chk("accept_seen", ok, 1);
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 10; n++) begin
            if (bus.out_valid) break;
            tick();
        end
        chk("out_valid_rise", bus.out_valid, 1);
    endtask

    task automatic wait_xfer();
        for (int n = 0; n < 30; n++) begin
            if (out_log.size() > 0) break;
            tick();
        end
    endtask

    task automatic check_beat(input string tag, input logic [AW-1:0] acc);
        xfer_t x;
        int    aa;
        chk({tag, "_xfer_seen"}, out_log.size() > 0, 1);
        if (out_log.size() > 0) begin
            x = out_log.pop_front();
            chk({tag, "_data"},  x.data,  model(acc, model_batch));
            chk({tag, "_batch"}, x.batch, model_batch);
            chk({tag, "_last"},  x.last,  model_batch == BATCH-1);
        end
        chk({tag, "_rd_seen"}, rd_log.size() > 0, 1);
        if (rd_log.size() > 0) begin
            aa = rd_log.pop_front();
            chk({tag, "_aa"}, aa, model_batch);
        end
        model_batch = (model_batch + 1) % BATCH;
    endtask

    task automatic beat(input string tag, input logic [AW-1:0] acc, input int stall);
        bus.out_ready = (stall == 0);
        send(acc);
        if (stall > 0) begin
            wait_valid();
            repeat (stall) tick();
            bus.out_ready = 1'b1;
        end
        wait_xfer();
        check_beat(tag, acc);
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        model_batch = 0;
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        longint a0;
        longint a1;
        int     batch;
        int     e0;
        int     e1;
        bit     last;
    } vec_t;

    vec_t tbl [6];

    // ---------------- watchdog ---------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test --------------------------------------------
    initial begin
        logic [AW-1:0] acc;
        logic [AW-1:0] accs [5];
        int            gap  [5];
        int            exp_aa [5];
        bit            saw;
        longint        tmp;

        tbl[0] = '{43524164, 0,          0, 6,   255, 1'b0};
        tbl[1] = '{32767,    -6455296,   1, 0,   2,   1'b0};
        tbl[2] = '{98304,    -32768,     2, 1,   0,   1'b0};
        tbl[3] = '{-65536,   MAX34,      3, 254, 0,   1'b1};
        tbl[4] = '{0,        0,          0, 0,   255, 1'b0};
        tbl[5] = '{-1,       MAX34,      1, 0,   255, 1'b0};
        exp_aa = '{0, 1, 2, 3, 0};

        for (int b = 0; b < BATCH; b++)
            for (int l = 0; l < NUM; l++)
                rom[b][l] = longint'($urandom_range(0, 134217728)) - 67108864;
        rom[0][0] = -43163716;  rom[0][1] = 170595872;
        rom[1][0] = 0;          rom[1][1] = 6553600;
        rom[2][0] = -65536;     rom[2][1] = 32767;
        rom[3][0] = 16744447;   rom[3][1] = MIN34;
        for (int w = 0; w < 8; w++) rom_word[w] = '0;
        for (int b = 0; b < BATCH; b++)
            for (int l = 0; l < NUM; l++) begin
                tmp = rom[b][l];
                rom_word[b][l*W_BIAS +: W_BIAS] = tmp[W_BIAS-1:0];
            end

        rstn          = 1'b0;
        bus.clr       = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        bus.out_ready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_ready", bus.acc_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_batch", bus.out_batch, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_cena",      bus.bias_cena, 1);
        chk("rst_aa",        bus.bias_aa,   0);
        rstn = 1'b1;
        tick();
        out_log.delete();
        rd_log.delete();
        model_batch = 0;

        // ---- first beat: latency and single ROM read ----
        acc = rand_acc(0);
        acc = set_lane(acc, 0, 43524164);
        acc = set_lane(acc, 1, 0);
        bus.out_ready = 1'b1;
        send(acc);
        chk("lat_rd_count", rd_log.size(), 1);
        chk("lat_t1_valid", bus.out_valid, 0);
        chk("lat_t1_cena",  bus.bias_cena, 1);
        tick();
        chk("lat_t2_valid", bus.out_valid, 1);
        chk("lat_t2_lane0", bus.out_data[7:0],  6);
        chk("lat_t2_lane1", bus.out_data[15:8], 255);
        chk("lat_t2_batch", bus.out_batch, 0);
        chk("lat_t2_last",  bus.out_last,  0);
        tick();
        chk("lat_t3_valid", bus.out_valid, 0);
        chk("lat_rd_once",  rd_log.size(), 1);
        check_beat("lat", acc);
        do_clr();

        // ---- table-driven beats ----
        for (int i = 0; i < 6; i++) begin
            acc = rand_acc(tbl[i].batch);
            acc = set_lane(acc, 0, tbl[i].a0);
            acc = set_lane(acc, 1, tbl[i].a1);
            bus.out_ready = 1'b1;
            send(acc);
            wait_xfer();
            if (out_log.size() > 0) begin
                chk($sformatf("tbl%0d_lane0", i), out_log[0].data[7:0],  tbl[i].e0);
                chk($sformatf("tbl%0d_lane1", i), out_log[0].data[15:8], tbl[i].e1);
                chk($sformatf("tbl%0d_batch", i), out_log[0].batch,      tbl[i].batch);
                chk($sformatf("tbl%0d_last",  i), out_log[0].last,       tbl[i].last);
            end
            check_beat($sformatf("tbl%0d", i), acc);
        end

        // ---- back-to-back beats, acc_valid held high ----
        do_clr();
        bus.out_ready = 1'b1;
        bus.acc_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            accs[k] = rand_acc(k % BATCH);
            bus.acc_data = accs[k];
            gap[k] = 0;
            while (!bus.acc_ready && gap[k] < 20) begin
                tick();
                gap[k]++;
            end
            tick();
        end
        bus.acc_valid = 1'b0;
        repeat (3) tick();
        for (int k = 1; k < 5; k++) chk($sformatf("b2b_gap%0d", k), gap[k], 2);
        chk("b2b_rd_count",  rd_log.size(),  5);
        chk("b2b_out_count", out_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < rd_log.size()) chk($sformatf("b2b_aa%0d", k), rd_log[k], exp_aa[k]);
            if (k < out_log.size()) chk($sformatf("b2b_last%0d", k), out_log[k].last, k == 3);
        end
        for (int k = 0; k < 5; k++) check_beat($sformatf("b2b%0d", k), accs[k]);

        // ---- back-pressure: out_ready low for 5 cycles ----
        acc = rand_acc(model_batch);
        bus.out_ready = 1'b0;
        send(acc);
        wait_valid();
        bus.acc_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), bus.out_valid, 1);
            chk($sformatf("stall%0d_data",  c), bus.out_data,  model(acc, model_batch));
            chk($sformatf("stall%0d_ready", c), bus.acc_ready, 0);
            tick();
        end
        bus.acc_valid = 1'b0;
        chk("stall_no_xfer", out_log.size(), 0);
        chk("stall_rd_once", rd_log.size(),  1);
        bus.out_ready = 1'b1;
        tick();
        chk("stall_xfer_one", out_log.size(), 1);
        tick();
        chk("stall_valid_drop", bus.out_valid, 0);
        chk("stall_idle_ready", bus.acc_ready, 1);
        chk("stall_single",     out_log.size(), 1);
        check_beat("stall", acc);

        // ---- clr while in BIAS on batch 2 ----
        for (int k = 0; k < BATCH && model_batch != 2; k++)
            beat($sformatf("pre_clr%0d", k), rand_acc(model_batch), 0);
        bus.out_ready = 1'b1;
        send(rand_acc(2));
        chk("clr_bias_rd_aa", (rd_log.size() > 0) ? rd_log[0] : -1, 2);
        rd_log.delete();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            saw |= bus.out_valid;
            tick();
        end
        chk("clr_bias_no_valid", saw, 0);
        chk("clr_bias_no_xfer",  out_log.size(), 0);
        model_batch = 0;
        acc = rand_acc(0);
        beat("after_clr", acc, 0);

        // ---- clr coincident with acc handshake ----
        bus.acc_valid = 1'b1;
        bus.acc_data  = rand_acc(model_batch);
        bus.clr       = 1'b1;
        #1;
        chk("clr_hs_cena", bus.bias_cena, 1);
        tick();
        bus.clr       = 1'b0;
        bus.acc_valid = 1'b0;
        repeat (4) tick();
        chk("clr_hs_no_rd",    rd_log.size(),  0);
        chk("clr_hs_no_xfer",  out_log.size(), 0);
        chk("clr_hs_no_valid", bus.out_valid,  0);
        model_batch = 0;
        beat("after_clr_hs", rand_acc(0), 0);

        // ---- asynchronous reset while in OUT ----
        bus.out_ready = 1'b0;
        send(rand_acc(model_batch));
        wait_valid();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_cena",  bus.bias_cena, 1);
        chk("arst_ready", bus.acc_ready, 0);
        chk("arst_data",  bus.out_data,  0);
        chk("arst_batch", bus.out_batch, 0);
        chk("arst_last",  bus.out_last,  0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        out_log.delete();
        rd_log.delete();
        model_batch = 0;
        tick();
        chk("arst_idle_ready", bus.acc_ready, 1);
        beat("after_arst", rand_acc(0), 0);

        // ---- randomized beats with random back-pressure ----
        for (int i = 0; i < 40; i++)
            beat($sformatf("rnd%0d", i), rand_acc(model_batch), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc1_bias_act.md
Name: fc1_bias_act

Overview:
- Post-accumulator stage of the FC1 layer. Consumes one output batch of 16 raw MAC sums per beat, fetches that batch's biases from the FC1 bias ROM, adds them, applies ReLU, rounds, shifts and saturates to 8-bit activations.
- Drives the ROM's address/enable directly and hands activations to the FC2 input buffer over a valid/ready interface.

Parameters:
- NUM, 16, lanes per batch (matches FC1 ROM word)
- BATCH, 4, output batches per frame
- ADDR_W, 3, ROM address width
- W_ACC, 34, signed accumulator width per lane
- W_BIAS, 34, signed bias width per lane
- W_OUT, 8, unsigned activation width
- SHIFT, 16, requantisation right shift (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame restart
- acc_valid  in  1  accumulator beat valid
- acc_ready  out  1  stage can accept beat
- acc_data  in  NUM*W_ACC  packed signed sums, lane 0 in LSBs
- bias_aa  out  ADDR_W  ROM address
- bias_cena  out  1  ROM read enable, active low
- bias_qa  in  NUM*W_BIAS  ROM data, registered, valid the cycle after cena low
- out_valid  out  1  activation beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM*W_OUT  packed activations, lane 0 in LSBs
- out_batch  out  ADDR_W  batch index of out_data
- out_last  out  1  high on beat of batch BATCH-1

Behaviour:
- Reset (rstn low, async): state IDLE, batch_cnt 0, acc_ready 0 while asserted, out_valid 0, out_data 0, out_batch 0, out_last 0, bias_cena 1, bias_aa 0.
- FSM IDLE -> BIAS -> OUT -> IDLE.
- IDLE: acc_ready=1. On acc_valid&acc_ready: register acc_data, assert bias_cena=0 and bias_aa=batch_cnt combinationally in that same cycle, go BIAS.
- bias_cena is high in every other cycle; bias_aa holds batch_cnt.
- BIAS: acc_ready=0. bias_qa is valid. Compute all lanes, register into out_data, set out_valid=1, out_batch=batch_cnt, out_last=(batch_cnt==BATCH-1). Go OUT.
- OUT: out_valid held with out_data stable until out_ready. On the handshake:
  - out_valid drops next cycle.
  - batch_cnt = (batch_cnt==BATCH-1) ? 0 : batch_cnt+1.
  - Go IDLE.
- Latency: accept at cycle t gives out_valid at t+2. Maximum throughput is 1 beat per 3 cycles.
- Per-lane arithmetic:
  - sum = sext(acc)+sext(bias) at W_ACC+1 bits, no overflow.
  - sum<0 → 0.
  - Otherwise r = (sum + 2^(SHIFT-1)) >> SHIFT (round half up), and out = min(r, 2^W_OUT-1).
- clr: synchronous, highest priority. Forces IDLE, batch_cnt 0, out_valid 0, out_last 0. Any beat in flight is dropped. A handshake in the same cycle as clr is ignored, with no ROM read issued (bias_cena stays 1).
- acc_valid while not IDLE is ignored (acc_ready=0).
- out_ready without out_valid has no effect.
- Reset mid-operation returns immediately to reset values; the pending beat is lost.

Test Plan:
- Reset, then batch 0 beat with lane0 acc = 43524164 (bias lane0 = -43163716, sum 360448), out_ready=1 → out_valid at t+2, lane0 = 6 (half rounds up), out_batch 0, out_last 0, bias_cena low exactly 1 cycle with aa=0.
- Batch 0 beat, all acc=0 → lane0 = 0 (negative, ReLU) and lane1 = 255 (bias 170595872 saturates).
- Four beats back-to-back, out_ready=1 → bias_aa sequence 0,1,2,3, out_last only on 4th, fifth beat reads aa=0.
- out_ready held 0 for 5 cycles in OUT → out_data/out_valid stable, acc_ready=0, no ROM read; release → single transfer, then IDLE.
- clr asserted in BIAS at batch 2 → out_valid never rises, next accepted beat uses aa=0; clr coincident with acc handshake → beat dropped, bias_cena stays 1.
- rstn pulsed low during OUT → out_valid 0 and bias_cena 1 immediately (async), batch_cnt 0 after release.
